mem_dump_ctrl: RTL and testbench

MEM_DUMP_CTRL -- requirements
Module: mem_dump_ctrl

---
 rtl/mem_dump_ctrl.sv | 91 +++++++++
 tb/tb_mem_dump_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_ctrl.sv
// mem_dump_ctrl: delayed, flow-controlled dump of an inclusive memory word range
module mem_dump_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 26,
  parameter int WAIT_CYCLES = 200,
  parameter bit CONTINUOUS  = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [ADDR_WIDTH-1:0] RANGE_LO,
  input  logic [ADDR_WIDTH-1:0] RANGE_HI,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic                  MEM_READ,
  input  logic [DATA_WIDTH-1:0] MEM_DATA_IN,
  output logic [DATA_WIDTH-1:0] DUMP_DATA,
  output logic [ADDR_WIDTH-1:0] DUMP_ADDR,
  output logic                  DUMP_VALID,
  input  logic                  DUMP_READY,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR
);
  localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
  typedef enum logic [2:0] {IDLE, DELAY, RD, CAP, OUT, FIN} state_t;
  localparam state_t ARM = WAIT_CYCLES == 0 ? RD : DELAY;
  state_t r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_lo, r_hi, r_addr, r_daddr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [CW-1:0] r_cnt;
  logic r_done, r_err;
  logic w_bad, w_go, w_last;
  assign w_bad      = RANGE_LO > RANGE_HI;
  assign w_go       = r_state == IDLE && START && !w_bad;
  assign w_last     = r_addr == r_hi;
  assign MEM_ADDR   = r_addr;
  assign MEM_READ   = r_state == RD;
  assign DUMP_DATA  = r_data;
  assign DUMP_ADDR  = r_daddr;
  assign DUMP_VALID = r_state == OUT;
  assign BUSY       = r_state != IDLE;
  assign DONE       = r_done;
  assign ERR        = r_err;
  // state register
  always_ff @(posedge CLK) r_state <= !RST ? IDLE : w_next;
  // next-state: the last word never increments the address, so no wrap at the top of memory
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_go ? ARM : IDLE;
      DELAY:   w_next = r_cnt == LAST ? RD : DELAY;
      RD:      w_next = CAP;
      CAP:     w_next = OUT;
      OUT:     w_next = DUMP_READY ? (w_last ? FIN : RD) : OUT;
      FIN:     w_next = CONTINUOUS ? ARM : IDLE;
      default: w_next = IDLE;
    endcase
  end
  // range latch, delay counter, address walk, capture and status flags
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_lo    <= '0;
      r_hi    <= '0;
      r_addr  <= '0;
      r_daddr <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= r_state == IDLE && START && w_bad;
      r_cnt <= r_state == DELAY ? r_cnt + 1'b1 : '0;
      if (w_go) begin
        r_lo   <= RANGE_LO;
        r_hi   <= RANGE_HI;
        r_addr <= RANGE_LO;
        r_done <= 1'b0;
      end
      if (r_state == CAP) begin
        r_data  <= MEM_DATA_IN;
        r_daddr <= r_addr;
      end
      if (r_state == OUT && DUMP_READY && !w_last) r_addr <= r_addr + 1'b1;
      if (r_state == FIN) begin
        r_done <= 1'b1;
        r_addr <= r_lo;
      end
    end
  end
endmodule

// File: tb/tb_mem_dump_ctrl.sv
// tb_mem_dump_ctrl: directed vector bench for mem_dump_ctrl (one-shot, continuous and zero-wait builds)
module tb_mem_dump_ctrl;
  localparam int AW = 26, DW = 32;
  typedef struct {int c; logic [AW-1:0] a; logic [DW-1:0] d;} ev_t;
  typedef struct {logic [AW-1:0] lo; logic [AW-1:0] hi; int n; bit err;} vec_t;
  logic CLK = 1'b0, RST = 1'b0, DUMP_READY = 1'b1;
  logic st[3];
  logic [AW-1:0] RANGE_LO = '0, RANGE_HI = '0;
  logic [AW-1:0] ma[3], da[3];
  logic [DW-1:0] md[3], dd[3];
  logic rd[3], dv[3], busy[3], done[3], err[3];
  int cyc = 0, n_tests = 0, n_fail = 0, nb0 = 0;
  ev_t x0[$], r0[$], x1[$], r1[$], x2[$], r2[$];
  int e0[$];
  vec_t tv[5];
  mem_dump_ctrl #(.WAIT_CYCLES(4)) dut0 (.CLK(CLK), .RST(RST), .START(st[0]), .RANGE_LO(RANGE_LO), .RANGE_HI(RANGE_HI),
    .MEM_ADDR(ma[0]), .MEM_READ(rd[0]), .MEM_DATA_IN(md[0]), .DUMP_DATA(dd[0]), .DUMP_ADDR(da[0]), .DUMP_VALID(dv[0]),
    .DUMP_READY(DUMP_READY), .BUSY(busy[0]), .DONE(done[0]), .ERR(err[0]));
  mem_dump_ctrl #(.WAIT_CYCLES(4), .CONTINUOUS(1'b1)) dut1 (.CLK(CLK), .RST(RST), .START(st[1]), .RANGE_LO(RANGE_LO), .RANGE_HI(RANGE_HI),
    .MEM_ADDR(ma[1]), .MEM_READ(rd[1]), .MEM_DATA_IN(md[1]), .DUMP_DATA(dd[1]), .DUMP_ADDR(da[1]), .DUMP_VALID(dv[1]),
    .DUMP_READY(DUMP_READY), .BUSY(busy[1]), .DONE(done[1]), .ERR(err[1]));
  mem_dump_ctrl #(.WAIT_CYCLES(0)) dut2 (.CLK(CLK), .RST(RST), .START(st[2]), .RANGE_LO(RANGE_LO), .RANGE_HI(RANGE_HI),
    .MEM_ADDR(ma[2]), .MEM_READ(rd[2]), .MEM_DATA_IN(md[2]), .DUMP_DATA(dd[2]), .DUMP_ADDR(da[2]), .DUMP_VALID(dv[2]),
    .DUMP_READY(DUMP_READY), .BUSY(busy[2]), .DONE(done[2]), .ERR(err[2]));
  function automatic logic [DW-1:0] mval(input logic [AW-1:0] a);
    return DW'(a) * DW'(3);
  endfunction
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  // memory model: data valid only in the cycle right after a read strobe
  always @(posedge CLK) for (int i = 0; i < 3; i++) md[i] <= rd[i] ? mval(ma[i]) : 32'hDEAD_BEEF;
  // monitor: record transfers, reads and error pulses mid-cycle
  always @(negedge CLK) begin
    if (dv[0] && DUMP_READY) x0.push_back('{cyc, da[0], dd[0]});
    if (rd[0]) r0.push_back('{cyc, ma[0], '0});
    if (err[0]) e0.push_back(cyc);
    if (busy[0]) nb0 <= nb0 + 1;
    if (dv[1] && DUMP_READY) x1.push_back('{cyc, da[1], dd[1]});
    if (rd[1]) r1.push_back('{cyc, ma[1], '0});
    if (dv[2] && DUMP_READY) x2.push_back('{cyc, da[2], dd[2]});
    if (rd[2]) r2.push_back('{cyc, ma[2], '0});
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic pulse(input int i, input logic [AW-1:0] lo, input logic [AW-1:0] hi, output int sc);
    RANGE_LO = lo;
    RANGE_HI = hi;
    st[i] = 1'b1;
    @(negedge CLK);
    sc = cyc;
    @(posedge CLK);
    #1 st[i] = 1'b0;
  endtask
  task automatic wait_idle(input int i, input string nm);
    int n = 0;
    while (busy[i] && n < 300) begin
      @(posedge CLK);
      #1 n++;
    end
    chk({nm, "_idle"}, busy[i], 0);
  endtask
  task automatic wait_out11();
    int n = 0;
    while (!(dv[0] && da[0] == 26'h11) && n < 60) begin
      @(posedge CLK);
      #1 n++;
    end
    chk("reach_out_0x11", dv[0] && da[0] == 26'h11, 1);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int sc, nb, sv, sd, sr, bad;
    logic [AW-1:0] a;
    tv[0] = '{26'h10, 26'h13, 4, 1'b0};
    tv[1] = '{26'h20, 26'h1F, 0, 1'b1};
    tv[2] = '{26'h3FFFFFF, 26'h3FFFFFF, 1, 1'b0};
    tv[3] = '{26'h5, 26'h5, 1, 1'b0};
    tv[4] = '{26'h0, 26'h2, 3, 1'b0};
    for (int i = 0; i < 3; i++) st[i] = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_busy", busy[0], 0);
    chk("reset_done", done[0], 0);
    chk("reset_err", err[0], 0);
    chk("reset_valid", dv[0], 0);
    chk("reset_read", rd[0], 0);
    chk("reset_addr", ma[0], 0);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    for (int k = 0; k < 5; k++) begin
      x0.delete(); r0.delete(); e0.delete();
      nb = nb0;
      pulse(0, tv[k].lo, tv[k].hi, sc);
      wait_idle(0, "vec");
      repeat (3) @(posedge CLK);
      #1;
      chk("n_xfer", x0.size(), tv[k].n);
      chk("n_read", r0.size(), tv[k].n);
      chk("err_pulses", e0.size(), tv[k].err ? 1 : 0);
      if (tv[k].err) begin
        chk("err_cycle", e0.size() > 0 ? e0[0] - sc : -1, 1);
        chk("busy_on_err", nb0 - nb, 0);
      end else begin
        chk("first_read_delay", r0.size() > 0 ? r0[0].c - sc : -1, 5);
        chk("done", done[0], 1);
        for (int j = 0; j < tv[k].n && j < x0.size() && j < r0.size(); j++) begin
          a = tv[k].lo + AW'(j);
          chk("xfer_addr", x0[j].a, a);
          chk("xfer_data", x0[j].d, mval(a));
          chk("read_addr", r0[j].a, a);
          if (j > 0) chk("xfer_gap", x0[j].c - x0[j-1].c, 3);
        end
      end
    end
    x0.delete(); r0.delete();
    pulse(0, 26'h10, 26'h13, sc);
    wait_out11();
    DUMP_READY = 1'b0;
    sv = 0; sd = 0; sr = 0;
    repeat (7) begin
      @(negedge CLK);
      sv += int'(dv[0]);
      sd += int'(dd[0] == 32'h33 && da[0] == 26'h11);
      sr += int'(rd[0]);
      @(posedge CLK);
      #1;
    end
    DUMP_READY = 1'b1;
    wait_idle(0, "stall");
    chk("stall_valid", sv, 7);
    chk("stall_data", sd, 7);
    chk("stall_reads", sr, 0);
    chk("stall_n_xfer", x0.size(), 4);
    if (x0.size() >= 3) begin
      chk("stall_gap", x0[1].c - x0[0].c, 10);
      chk("stall_data_out", x0[1].d, 32'h33);
      chk("after_stall_gap", x0[2].c - x0[1].c, 3);
    end
    x0.delete(); r0.delete();
    pulse(0, 26'h10, 26'h13, sc);
    wait_out11();
    DUMP_READY = 1'b0;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    chk("rst_mem_addr", ma[0], 0);
    chk("rst_mem_read", rd[0], 0);
    chk("rst_dump_data", dd[0], 0);
    chk("rst_dump_addr", da[0], 0);
    chk("rst_dump_valid", dv[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_err", err[0], 0);
    RST = 1'b1;
    DUMP_READY = 1'b1;
    repeat (8) @(posedge CLK);
    #1;
    chk("rst_aborted_xfers", x0.size(), 1);
    chk("rst_stays_idle", busy[0], 0);
    x0.delete(); r0.delete();
    pulse(0, 26'h10, 26'h11, sc);
    wait_idle(0, "restart");
    chk("restart_n_xfer", x0.size(), 2);
    chk("restart_first_read", r0.size() > 0 ? r0[0].a : '1, 26'h10);
    chk("restart_first_xfer", x0.size() > 0 ? x0[0].d : '1, 32'h30);
    x1.delete(); r1.delete();
    pulse(1, 26'h40, 26'h41, sc);
    repeat (3) @(posedge CLK);
    #1;
    RANGE_LO = 26'h50;
    RANGE_HI = 26'h60;
    st[1] = 1'b1;
    @(posedge CLK);
    #1 st[1] = 1'b0;
    repeat (30) @(posedge CLK);
    #1;
    chk("cont_busy", busy[1], 1);
    chk("cont_done", done[1], 1);
    chk("cont_first_read", r1.size() > 0 ? r1[0].c - sc : -1, 5);
    bad = 0;
    foreach (r1[j]) bad += int'(r1[j].a != 26'h40 && r1[j].a != 26'h41);
    chk("cont_bad_reads", bad, 0);
    chk("cont_n_ge4", x1.size() >= 4, 1);
    if (x1.size() >= 4) begin
      chk("cont_a0", x1[0].a, 26'h40);
      chk("cont_a1", x1[1].a, 26'h41);
      chk("cont_a2", x1[2].a, 26'h40);
      chk("cont_d3", x1[3].d, 32'hC3);
      chk("cont_gap_word", x1[1].c - x1[0].c, 3);
      chk("cont_gap_rearm", x1[2].c - x1[1].c, 8);
    end
    RST = 1'b0;
    @(posedge CLK);
    #1 RST = 1'b1;
    chk("cont_reset_busy", busy[1], 0);
    x2.delete(); r2.delete();
    pulse(2, 26'h7, 26'h8, sc);
    wait_idle(2, "w0");
    chk("w0_first_read", r2.size() > 0 ? r2[0].c - sc : -1, 1);
    chk("w0_n_xfer", x2.size(), 2);
    if (x2.size() >= 2) begin
      chk("w0_data", x2[0].d, 32'h15);
      chk("w0_gap", x2[1].c - x2[0].c, 3);
    end
    chk("w0_done", done[2], 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
